hist_bank_param: RTL and testbench

//  Parametrised multi-lane histogram counter bank for the SIMD datapath.

---
 rtl/hist_pkg.sv | 24 ++
 rtl/hist_bank_param_if.sv | 27 ++
 rtl/hist_lane_count.sv | 23 ++
 rtl/hist_bank_param.sv | 144 ++++++++++++++
 tb/tb_hist_bank_param.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hist_pkg.sv
// Shared types and default geometry for the histogram counter bank.
package hist_pkg;

  localparam int DEF_LANES       = 8;
  localparam int DEF_BINS        = 256;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_CLR_PER_CYC = 16;

  localparam int BIN_W  = $clog2(DEF_BINS);
  localparam int INC_W  = $clog2(DEF_LANES + 1);
  localparam int CHUNKS = DEF_BINS / DEF_CLR_PER_CYC;

  typedef enum logic {IDLE, CLEAR} hist_state_t;

  typedef logic [BIN_W-1:0]     bin_idx_t;
  typedef logic [DEF_CNT_W-1:0] cnt_t;
  typedef logic [INC_W-1:0]     inc_t;

  // Width needed to hold a hit count of 0..lanes.
  function automatic int inc_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/hist_bank_param_if.sv
// Update / read / clear bundle between the vector LSU and the histogram bank.
interface hist_bank_param_if #(
  parameter int LANES = 8,
  parameter int BIN_W = 8,
  parameter int CNT_W = 16
);
  logic                   upd_valid;
  logic                   upd_ready;
  logic [LANES*BIN_W-1:0] upd_bin;
  logic [LANES-1:0]       upd_mask;
  logic [LANES*BIN_W-1:0] rd_addr;
  logic [LANES*CNT_W-1:0] rd_data;
  logic                   clr_start;
  logic                   busy;
  logic                   clr_done;
  logic                   ovf;

  modport master (
    output upd_valid, upd_bin, upd_mask, rd_addr, clr_start,
    input  upd_ready, rd_data, busy, clr_done, ovf
  );

  modport slave (
    input  upd_valid, upd_bin, upd_mask, rd_addr, clr_start,
    output upd_ready, rd_data, busy, clr_done, ovf
  );
endinterface

// File: rtl/hist_lane_count.sv
// Counts how many enabled lanes target one fixed bin (combinational).
module hist_lane_count
  import hist_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int BIN_W = 8,
  parameter int INC_W = 4
) (
  input  logic [LANES*BIN_W-1:0] upd_bin,
  input  logic [LANES-1:0]       upd_mask,
  input  logic [BIN_W-1:0]       bin_idx,
  output logic [INC_W-1:0]       hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < LANES; i++) begin
      if (upd_mask[i] && (upd_bin[i*BIN_W +: BIN_W] == bin_idx))
        hit = hit + INC_W'(1);
    end
  end

endmodule

// File: rtl/hist_bank_param.sv
// Multi-lane histogram bank: one update per cycle in IDLE, 1-cycle registered reads, chunked clear.
// Define HIST_SAT_EN to saturate bins at all-ones instead of wrapping; ovf is sticky either way.
module hist_bank_param
  import hist_pkg::*;
#(
  parameter int LANES       = DEF_LANES,
  parameter int BINS        = DEF_BINS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CLR_PER_CYC = DEF_CLR_PER_CYC
) (
  input logic         clk,
  input logic         rst,
  hist_bank_param_if.slave bus
);

  localparam int BW  = $clog2(BINS);
  localparam int IW  = inc_width(LANES);
  localparam int NCH = BINS / CLR_PER_CYC;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW  = CNT_W + 1;

  hist_state_t            state;
  logic [KW-1:0]          chunk;
  logic                   busy_q;
  logic                   done_q;
  logic                   rdy_q;
  logic                   ovf_q;
  logic [LANES*CNT_W-1:0] rd_q;

  logic [CNT_W-1:0] cnt [BINS];
  logic [CNT_W-1:0] nxt [BINS];
  logic [IW-1:0]    hit [BINS];
  logic [BINS-1:0]  carry;
  logic [SW-1:0]    sum;

  logic fire;
  logic clr_go;

  assign fire   = bus.upd_valid && rdy_q;
  assign clr_go = bus.clr_start && (state == IDLE);

  for (genvar b = 0; b < BINS; b++) begin : g_bin
    hist_lane_count #(
      .LANES (LANES),
      .BIN_W (BW),
      .INC_W (IW)
    ) u_lane_count (
      .upd_bin  (bus.upd_bin),
      .upd_mask (bus.upd_mask),
      .bin_idx  (BW'(b)),
      .hit      (hit[b])
    );
  end

  always_comb begin
    sum   = '0;
    carry = '0;
    for (int b = 0; b < BINS; b++) begin
      sum      = {1'b0, cnt[b]} + SW'(hit[b]);
      carry[b] = sum[CNT_W];
`ifdef HIST_SAT_EN
      nxt[b]   = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
`else
      nxt[b]   = sum[CNT_W-1:0];
`endif
    end
  end

  // Updates never fire during CLEAR, so the sweep and the add path never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < BINS; b++) cnt[b] <= '0;
    end else begin
      for (int b = 0; b < BINS; b++) begin
        if (state == CLEAR && chunk == KW'(b / CLR_PER_CYC))
          cnt[b] <= '0;
        else if (fire)
          cnt[b] <= nxt[b];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        rd_q[i*CNT_W +: CNT_W] <= cnt[bus.rd_addr[i*BW +: BW]];
    end
  end

  // A clear request wins over an overflow from an update in the same cycle:
  // the overflowed bin is about to be zeroed anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (clr_go)
      ovf_q <= 1'b0;
    else if (fire && |carry)
      ovf_q <= 1'b1;
  end

  // clr_done is raised while the final chunk is being written, so busy drops one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      chunk  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.clr_start) begin
            state  <= CLEAR;
            chunk  <= '0;
            busy_q <= 1'b1;
            rdy_q  <= 1'b0;
            done_q <= (NCH == 1);
          end
        end
        CLEAR: begin
          if (chunk == KW'(NCH - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            rdy_q  <= 1'b1;
            done_q <= 1'b0;
          end else begin
            chunk  <= chunk + KW'(1);
            done_q <= (chunk == KW'(NCH - 2));
          end
        end
      endcase
    end
  end

  assign bus.upd_ready = rdy_q;
  assign bus.busy      = busy_q;
  assign bus.clr_done  = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.rd_data   = rd_q;

endmodule

// File: tb/tb_hist_bank_param.sv
// Bench for hist_bank_param: directed vector table, clear/overflow/reset sequences, random vs. model.
module tb_hist_bank_param;

  localparam int L   = 8;
  localparam int NB  = 256;
  localparam int CW  = 16;
  localparam int SCW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hist_bank_param_if #(.LANES(L), .BIN_W(8), .CNT_W(CW))  b0 ();
  hist_bank_param_if #(.LANES(L), .BIN_W(8), .CNT_W(SCW)) b1 ();

  hist_bank_param #(.LANES(L), .BINS(NB), .CNT_W(CW), .CLR_PER_CYC(16)) dut (
    .clk (clk), .rst (rst), .bus (b0.slave)
  );

  hist_bank_param #(.LANES(L), .BINS(NB), .CNT_W(SCW), .CLR_PER_CYC(16)) dut_s (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );

  typedef int lanes_t [8];
  typedef struct {
    lanes_t lb;
    int     mask;
    int     qb  [4];
    int     exp [4];
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int model [NB];
  bit model_ovf;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rd0(input int i);
    return int'(b0.rd_data[i*CW +: CW]);
  endfunction

  task automatic drive0(input lanes_t lb, input int mask);
    b0.upd_valid = 1'b1;
    for (int i = 0; i < L; i++) b0.upd_bin[i*8 +: 8] = 8'(lb[i]);
    b0.upd_mask = 8'(mask);
  endtask

  task automatic drive1(input int bin, input int mask);
    b1.upd_valid = 1'b1;
    for (int i = 0; i < L; i++) b1.upd_bin[i*8 +: 8] = 8'(bin);
    b1.upd_mask = 8'(mask);
  endtask

  // Reference: each enabled lane adds one to its bin; out-of-range totals flag overflow.
  task automatic model_apply(input lanes_t lb, input int mask);
    for (int i = 0; i < L; i++)
      if (((mask >> i) & 1) == 1) model[lb[i]]++;
    for (int b = 0; b < NB; b++) begin
      if (model[b] > (1 << CW) - 1) begin
        model_ovf = 1'b1;
`ifdef HIST_SAT_EN
        model[b] = (1 << CW) - 1;
`else
        model[b] = model[b] - (1 << CW);
`endif
      end
    end
  endtask

  task automatic model_zero();
    for (int b = 0; b < NB; b++) model[b] = 0;
    model_ovf = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t   vt [4];
    lanes_t lb;
    int     exp_rd [8];
    int     pre;

    vt[0] = '{'{5, 5, 5, 5, 5, 5, 5, 5},         'hFF, '{5, 0, 1, 4},    '{8, 0, 0, 0}};
    vt[1] = '{'{3, 3, 7, 200, 9, 9, 9, 9},       'h0F, '{3, 7, 200, 9},  '{2, 1, 1, 0}};
    vt[2] = '{'{5, 5, 5, 5, 3, 3, 0, 255},       'hF3, '{5, 3, 0, 255},  '{10, 4, 1, 1}};
    vt[3] = '{'{7, 7, 7, 7, 7, 7, 7, 7},         'h00, '{7, 5, 3, 200},  '{1, 10, 4, 1}};

    rst = 1'b1;
    b0.upd_valid = 1'b0; b0.upd_bin = '0; b0.upd_mask = '0; b0.rd_addr = '0; b0.clr_start = 1'b0;
    b1.upd_valid = 1'b0; b1.upd_bin = '0; b1.upd_mask = '0; b1.rd_addr = '0; b1.clr_start = 1'b0;
    model_zero();
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_upd_ready", b0.upd_ready, 1);
    chk("rst_busy", b0.busy, 0);
    chk("rst_ovf", b0.ovf, 0);
    chk("rst_clr_done", b0.clr_done, 0);
    chk("rst_rd_data", b0.rd_data, 0);
    chk("rst_s_upd_ready", b1.upd_ready, 1);
    for (int i = 0; i < L; i++) b0.rd_addr[i*8 +: 8] = 8'($urandom_range(0, 255));
    step();
    for (int i = 0; i < L; i++) chk("rst_read", rd0(i), 0);

    // Directed vector table
    for (int v = 0; v < 4; v++) begin
      pre = model[vt[v].qb[0]];
      drive0(vt[v].lb, vt[v].mask);
      b0.rd_addr = '0;
      b0.rd_addr[7:0] = 8'(vt[v].qb[0]);
      chk("vec_upd_ready", b0.upd_ready, 1);
      model_apply(vt[v].lb, vt[v].mask);
      step();
      b0.upd_valid = 1'b0;
      chk("vec_same_cycle_rd", rd0(0), pre);
      for (int j = 0; j < 4; j++) b0.rd_addr[j*8 +: 8] = 8'(vt[v].qb[j]);
      step();
      for (int j = 0; j < 4; j++) chk("vec_rd", rd0(j), vt[v].exp[j]);
    end

    // Clear sweep; updates held pending and a second clr_start must not extend it
    b0.clr_start = 1'b1;
    step();
    b0.clr_start = 1'b0;
    lb = '{5, 5, 5, 5, 5, 5, 5, 5};
    drive0(lb, 'hFF);
    for (int c = 1; c <= 16; c++) begin
      chk("clr_busy", b0.busy, 1);
      chk("clr_upd_ready", b0.upd_ready, 0);
      chk("clr_done_pulse", b0.clr_done, (c == 16) ? 1 : 0);
      b0.clr_start = (c == 5);
      step();
    end
    b0.clr_start = 1'b0;
    b0.upd_valid = 1'b0;
    chk("clr_end_busy", b0.busy, 0);
    chk("clr_end_upd_ready", b0.upd_ready, 1);
    chk("clr_end_done", b0.clr_done, 0);
    model_zero();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < L; i++) b0.rd_addr[i*8 +: 8] = 8'($urandom_range(0, 255));
      b0.rd_addr[7:0]   = 8'(5);
      b0.rd_addr[15:8]  = 8'(3);
      b0.rd_addr[23:16] = 8'(200);
      step();
      for (int i = 0; i < L; i++) chk("clr_read_zero", rd0(i), 0);
    end

    // Random updates and reads against the model
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < L; i++)
        lb[i] = (t % 2 == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
      b0.upd_valid = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < L; i++) b0.upd_bin[i*8 +: 8] = 8'(lb[i]);
      b0.upd_mask = 8'($urandom_range(0, 255));
      for (int i = 0; i < L; i++) begin
        b0.rd_addr[i*8 +: 8] = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                              : $urandom_range(0, 15));
        exp_rd[i] = model[b0.rd_addr[i*8 +: 8]];
      end
      chk("rnd_upd_ready", b0.upd_ready, 1);
      if (b0.upd_valid) model_apply(lb, int'(b0.upd_mask));
      step();
      for (int i = 0; i < L; i++) chk("rnd_rd", rd0(i), exp_rd[i]);
    end
    b0.upd_valid = 1'b0;
    chk("rnd_ovf", b0.ovf, model_ovf);

    // Narrow-counter overflow: preload 12, then add 8
    drive1(1, 'hFF);
    step();
    drive1(1, 'h0F);
    step();
    b1.upd_valid = 1'b0;
    b1.rd_addr[7:0] = 8'(1);
    step();
    chk("ovf_preload", int'(b1.rd_data[3:0]), 12);
    chk("ovf_before", b1.ovf, 0);
    drive1(1, 'hFF);
    step();
    b1.upd_valid = 1'b0;
    chk("ovf_set", b1.ovf, 1);
    step();
`ifdef HIST_SAT_EN
    chk("ovf_bin_value", int'(b1.rd_data[3:0]), 15);
`else
    chk("ovf_bin_value", int'(b1.rd_data[3:0]), 4);
`endif
    b1.clr_start = 1'b1;
    step();
    b1.clr_start = 1'b0;
    chk("ovf_cleared", b1.ovf, 0);
    for (int c = 0; c < 16; c++) step();
    chk("ovf_clr_busy", b1.busy, 0);
    chk("ovf_clr_bin", int'(b1.rd_data[3:0]), 0);

    // Reset in the middle of a clear sweep
    b0.clr_start = 1'b1;
    step();
    b0.clr_start = 1'b0;
    for (int c = 1; c < 7; c++) step();
    chk("rstclr_busy_before", b0.busy, 1);
    rst = 1'b1;
    #1;
    chk("rstclr_busy", b0.busy, 0);
    chk("rstclr_upd_ready", b0.upd_ready, 1);
    chk("rstclr_done", b0.clr_done, 0);
    step();
    chk("rstclr_done_hold", b0.clr_done, 0);
    step();
    rst = 1'b0;
    model_zero();
    for (int c = 0; c < 12; c++) begin
      chk("rstclr_no_done", b0.clr_done, 0);
      step();
    end
    chk("rstclr_upd_ready_after", b0.upd_ready, 1);
    chk("rstclr_busy_after", b0.busy, 0);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < L; i++) begin
        case (r)
          0: b0.rd_addr[i*8 +: 8] = 8'(i);
          1: b0.rd_addr[i*8 +: 8] = 8'(8 + i);
          2: b0.rd_addr[i*8 +: 8] = 8'(112 + i);
          3: b0.rd_addr[i*8 +: 8] = 8'(120 + i);
          default: b0.rd_addr[i*8 +: 8] = 8'($urandom_range(128, 255));
        endcase
      end
      step();
      for (int i = 0; i < L; i++) chk("rstclr_read_zero", rd0(i), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
